// File: rtl/comparator_csr_registers.sv
// comparator_csr_registers
// Avalon-MM control/status register block for the NMR fingerprint comparator.
// Configuration writes from the processor are forwarded to the core-assignment
// table, the maxcount counters and the directory pointers through strobe/ack
// handshakes. Comparator results are captured in the EXCEPTION, SUCCESS and
// FAIL registers and raise irq until the processor writes EXCEPTION.
module comparator_csr_registers #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 3,
    parameter int KEY_WIDTH      = 4,
    parameter int KEY_SIZE       = 16,
    parameter int RAM_ADDR_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic [CSR_ADDR_WIDTH-1:0] csr_address,
    input  logic                      csr_read,
    output logic [DATA_WIDTH-1:0]     csr_readdata,
    input  logic                      csr_write,
    input  logic [DATA_WIDTH-1:0]     csr_writedata,
    output logic                      csr_waitrequest,

    output logic [1:0]                csr_logical_core_id,
    output logic [KEY_WIDTH-1:0]      csr_task_id,
    output logic [KEY_WIDTH-1:0]      csr_physical_core_id,

    input  logic                      comparator_status_write,
    input  logic                      comparator_collision_detected,
    input  logic [1:0]                comparator_logical_core_id,
    input  logic [KEY_WIDTH-1:0]      comparator_task_id,
    output logic                      csr_status_ack,

    output logic                      csr_cat_write,
    input  logic                      fprint_cat_ack,

    output logic                      csr_maxcount_write,
    output logic [RAM_ADDR_WIDTH-1:0] csr_maxcount_data,
    input  logic                      counter_maxcount_ack,

    output logic                      csr_pointer_start_write,
    output logic                      csr_pointer_end_write,
    output logic [RAM_ADDR_WIDTH-1:0] csr_pointer_data,
    input  logic                      comp_pointer_ack,

    output logic                      irq
);

    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_EXCEPTION = CSR_ADDR_WIDTH'(0);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_SUCCESS   = CSR_ADDR_WIDTH'(1);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_FAIL      = CSR_ADDR_WIDTH'(2);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_CAT       = CSR_ADDR_WIDTH'(3);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MAXCOUNT  = CSR_ADDR_WIDTH'(4);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_DIR_START = CSR_ADDR_WIDTH'(5);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_DIR_END   = CSR_ADDR_WIDTH'(6);

    typedef enum logic [2:0] {
        IDLE,
        CAT_WAIT,
        MAX_WAIT,
        PSTART_WAIT,
        PEND_WAIT,
        DONE
    } state_t;

    state_t                    state;
    logic [KEY_WIDTH:0]        exception_reg;
    logic [KEY_SIZE-1:0]       success_reg;
    logic [2*KEY_SIZE-1:0]     fail_reg;
    logic [DATA_WIDTH-1:0]     read_value;
    logic                      exc_clear;
    logic                      accept;
    logic                      cfg_write;
    logic                      unused_writedata;

    // Only a few writedata fields are meaningful; fold the rest together so the
    // full bus counts as consumed.
    assign unused_writedata = ^csr_writedata;

    // Stall the master until the transaction reaches DONE.
    assign csr_waitrequest = (csr_read | csr_write) & (state != DONE);

    // The exception-clear write is decoded in IDLE and beats a comparator
    // result arriving in the same cycle.
    assign exc_clear = (state == IDLE) & csr_write & (csr_address == ADDR_EXCEPTION);
    assign accept    = comparator_status_write & ~irq & ~exc_clear;

    // Offsets 3..6 forward their fields to downstream tables.
    assign cfg_write = (csr_address == ADDR_CAT)       | (csr_address == ADDR_MAXCOUNT) |
                       (csr_address == ADDR_DIR_START) | (csr_address == ADDR_DIR_END);

    // Read multiplexer; write-only and unmapped offsets read as zero.
    always_comb begin
        read_value = '0;
        case (csr_address)
            ADDR_EXCEPTION: read_value = DATA_WIDTH'(exception_reg);
            ADDR_SUCCESS:   read_value = DATA_WIDTH'(success_reg);
            ADDR_FAIL:      read_value = DATA_WIDTH'(fail_reg);
            default:        read_value = '0;
        endcase
    end

    // Bus transaction state machine: read capture, field latching and the
    // strobe/ack handshakes towards the downstream blocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                   <= IDLE;
            csr_readdata            <= '0;
            csr_logical_core_id     <= '0;
            csr_task_id             <= '0;
            csr_physical_core_id    <= '0;
            csr_maxcount_data       <= '0;
            csr_pointer_data        <= '0;
            csr_cat_write           <= 1'b0;
            csr_maxcount_write      <= 1'b0;
            csr_pointer_start_write <= 1'b0;
            csr_pointer_end_write   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (csr_write) begin
                        if (cfg_write) begin
                            csr_logical_core_id  <= csr_writedata[25:24];
                            csr_task_id          <= csr_writedata[16 +: KEY_WIDTH];
                            csr_physical_core_id <= csr_writedata[KEY_WIDTH-1:0];
                            csr_maxcount_data    <= csr_writedata[RAM_ADDR_WIDTH-1:0];
                            csr_pointer_data     <= csr_writedata[RAM_ADDR_WIDTH-1:0];
                        end
                        case (csr_address)
                            ADDR_CAT: begin
                                csr_cat_write <= 1'b1;
                                state         <= CAT_WAIT;
                            end
                            ADDR_MAXCOUNT: begin
                                csr_maxcount_write <= 1'b1;
                                state              <= MAX_WAIT;
                            end
                            ADDR_DIR_START: begin
                                csr_pointer_start_write <= 1'b1;
                                state                   <= PSTART_WAIT;
                            end
                            ADDR_DIR_END: begin
                                csr_pointer_end_write <= 1'b1;
                                state                 <= PEND_WAIT;
                            end
                            default: state <= DONE;
                        endcase
                    end else if (csr_read) begin
                        csr_readdata <= read_value;
                        state        <= DONE;
                    end
                end
                CAT_WAIT: begin
                    if (fprint_cat_ack) begin
                        csr_cat_write <= 1'b0;
                        state         <= DONE;
                    end
                end
                MAX_WAIT: begin
                    if (counter_maxcount_ack) begin
                        csr_maxcount_write <= 1'b0;
                        state              <= DONE;
                    end
                end
                PSTART_WAIT: begin
                    if (comp_pointer_ack) begin
                        csr_pointer_start_write <= 1'b0;
                        state                   <= DONE;
                    end
                end
                PEND_WAIT: begin
                    if (comp_pointer_ack) begin
                        csr_pointer_end_write <= 1'b0;
                        state                 <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Result registers and interrupt: capture one comparator result at a time
    // and hold off further results until the processor clears the exception.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exception_reg  <= '0;
            success_reg    <= '0;
            fail_reg       <= '1;
            irq            <= 1'b0;
            csr_status_ack <= 1'b0;
        end else begin
            csr_status_ack <= accept;
            if (exc_clear) begin
                exception_reg <= '0;
                success_reg   <= '0;
                fail_reg      <= '1;
                irq           <= 1'b0;
            end else if (accept) begin
                exception_reg <= {comparator_collision_detected, comparator_task_id};
                if (comparator_collision_detected) begin
                    fail_reg[{comparator_task_id, 1'b0} +: 2] <= comparator_logical_core_id;
                end else begin
                    success_reg[comparator_task_id] <= 1'b1;
                end
                irq <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_comparator_csr_registers.sv
// tb_comparator_csr_registers
// Directed self-checking bench for the comparator CSR block.
module tb_comparator_csr_registers;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  csr_address = '0;
    logic        csr_read = 1'b0;
    logic [31:0] csr_readdata;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic        csr_waitrequest;
    logic [1:0]  csr_logical_core_id;
    logic [3:0]  csr_task_id;
    logic [3:0]  csr_physical_core_id;
    logic        comparator_status_write = 1'b0;
    logic        comparator_collision_detected = 1'b0;
    logic [1:0]  comparator_logical_core_id = '0;
    logic [3:0]  comparator_task_id = '0;
    logic        csr_status_ack;
    logic        csr_cat_write;
    logic        fprint_cat_ack = 1'b0;
    logic        csr_maxcount_write;
    logic [5:0]  csr_maxcount_data;
    logic        counter_maxcount_ack = 1'b0;
    logic        csr_pointer_start_write;
    logic        csr_pointer_end_write;
    logic [5:0]  csr_pointer_data;
    logic        comp_pointer_ack = 1'b0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    comparator_csr_registers dut (
        .clk                           (clk),
        .reset                         (reset),
        .csr_address                   (csr_address),
        .csr_read                      (csr_read),
        .csr_readdata                  (csr_readdata),
        .csr_write                     (csr_write),
        .csr_writedata                 (csr_writedata),
        .csr_waitrequest               (csr_waitrequest),
        .csr_logical_core_id           (csr_logical_core_id),
        .csr_task_id                   (csr_task_id),
        .csr_physical_core_id          (csr_physical_core_id),
        .comparator_status_write       (comparator_status_write),
        .comparator_collision_detected (comparator_collision_detected),
        .comparator_logical_core_id    (comparator_logical_core_id),
        .comparator_task_id            (comparator_task_id),
        .csr_status_ack                (csr_status_ack),
        .csr_cat_write                 (csr_cat_write),
        .fprint_cat_ack                (fprint_cat_ack),
        .csr_maxcount_write            (csr_maxcount_write),
        .csr_maxcount_data             (csr_maxcount_data),
        .counter_maxcount_ack          (counter_maxcount_ack),
        .csr_pointer_start_write       (csr_pointer_start_write),
        .csr_pointer_end_write         (csr_pointer_end_write),
        .csr_pointer_data              (csr_pointer_data),
        .comp_pointer_ack              (comp_pointer_ack),
        .irq                           (irq)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it and reports a failure with tag and values.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] strobes();
        return {28'b0, csr_cat_write, csr_maxcount_write, csr_pointer_start_write,
                csr_pointer_end_write};
    endfunction

    function automatic logic [31:0] fields();
        return {10'b0, csr_logical_core_id, csr_task_id, csr_physical_core_id,
                csr_maxcount_data, csr_pointer_data};
    endfunction

    // Full Avalon read with a bounded wait on waitrequest.
    task automatic do_read(input logic [2:0] addr, output logic [31:0] data);
        int n = 0;
        csr_address = addr;
        csr_read    = 1'b1;
        tick();
        while (csr_waitrequest && n < 8) begin
            tick();
            n++;
        end
        if (csr_waitrequest) check_output("read_timeout", {31'b0, csr_waitrequest}, 32'h0);
        data     = csr_readdata;
        csr_read = 1'b0;
        tick();
    endtask

    task automatic read_check(input string tag, input logic [2:0] addr,
                              input logic [31:0] expected);
        logic [31:0] data;
        do_read(addr, data);
        check_output(tag, data, expected);
    endtask

    // Write to a register that completes without a downstream handshake.
    task automatic do_write(input logic [2:0] addr, input logic [31:0] data);
        int n = 0;
        csr_address   = addr;
        csr_writedata = data;
        csr_write     = 1'b1;
        tick();
        while (csr_waitrequest && n < 8) begin
            tick();
            n++;
        end
        if (csr_waitrequest) check_output("write_timeout", {31'b0, csr_waitrequest}, 32'h0);
        csr_write = 1'b0;
        tick();
    endtask

    // Configuration write: check the strobe and fields, then acknowledge it.
    task automatic apply_stimulus(input string tag, input logic [2:0] addr,
                                  input logic [31:0] data, input logic [31:0] exp_strobes,
                                  input logic [31:0] exp_fields);
        csr_address   = addr;
        csr_writedata = data;
        csr_write     = 1'b1;
        tick();
        check_output({tag, "_strobe"}, strobes(), exp_strobes);
        check_output({tag, "_fields"}, fields(), exp_fields);
        check_output({tag, "_wait"}, {31'b0, csr_waitrequest}, 32'h1);
        tick();
        check_output({tag, "_held"}, strobes(), exp_strobes);
        case (addr)
            3'd3:    fprint_cat_ack = 1'b1;
            3'd4:    counter_maxcount_ack = 1'b1;
            default: comp_pointer_ack = 1'b1;
        endcase
        tick();
        check_output({tag, "_dropped"}, strobes(), 32'h0);
        check_output({tag, "_done"}, {31'b0, csr_waitrequest}, 32'h0);
        fprint_cat_ack       = 1'b0;
        counter_maxcount_ack = 1'b0;
        comp_pointer_ack     = 1'b0;
        csr_write            = 1'b0;
        tick();
        check_output({tag, "_after"}, fields(), exp_fields);
    endtask

    // Present one comparator result and wait (bounded) for its ack.
    task automatic send_result(input logic coll, input logic [1:0] logical,
                               input logic [3:0] task_id);
        int n = 0;
        comparator_status_write       = 1'b1;
        comparator_collision_detected = coll;
        comparator_logical_core_id    = logical;
        comparator_task_id            = task_id;
        tick();
        while (!csr_status_ack && n < 8) begin
            tick();
            n++;
        end
        check_output("status_ack", {31'b0, csr_status_ack}, 32'h1);
        comparator_status_write = 1'b0;
        tick();
        check_output("ack_pulse", {31'b0, csr_status_ack}, 32'h0);
        check_output("irq_set", {31'b0, irq}, 32'h1);
    endtask

    initial begin
        logic [31:0] exp_fail;
        logic [31:0] last_read;

        $display("[TB] start");

        // Reset values while reset is asserted and after release.
        tick();
        check_output("rst_strobes", strobes(), 32'h0);
        check_output("rst_fields", fields(), 32'h0);
        check_output("rst_readdata", csr_readdata, 32'h0);
        check_output("rst_irq_ack", {30'b0, irq, csr_status_ack}, 32'h0);
        reset = 1'b0;
        tick();
        read_check("rst_exception", 3'd0, 32'h0);
        read_check("rst_success", 3'd1, 32'h0);
        read_check("rst_fail", 3'd2, 32'hFFFF_FFFF);

        // Core-assignment write: logical 2, task 5, physical 10, data 0x0A.
        apply_stimulus("cat", 3'd3, 32'h0205_000A, 32'h8,
                       {10'b0, 2'd2, 4'd5, 4'd10, 6'd10, 6'd10});

        // Maxcount / directory writes for every task and logical id.
        for (int t = 0; t < 16; t++) begin
            for (int l = 0; l < 3; l++) begin
                logic [31:0] wd;
                logic [31:0] ef;
                wd = (32'(l) << 24) | (32'(t) << 16) | 32'd21;
                ef = {10'b0, 2'(l), 4'(t), 4'd5, 6'd21, 6'd21};
                apply_stimulus("maxcount", 3'd4, wd, 32'h4, ef);
                apply_stimulus("dir_start", 3'd5, wd, 32'h2, ef);
                apply_stimulus("dir_end", 3'd6, wd, 32'h1, ef);
            end
        end

        // Unmapped and write-only offsets read as zero; ignored writes complete.
        read_check("read_cat", 3'd3, 32'h0);
        read_check("read_off7", 3'd7, 32'h0);
        do_write(3'd1, 32'hFFFF_FFFF);
        do_write(3'd7, 32'hFFFF_FFFF);
        read_check("success_untouched", 3'd1, 32'h0);

        // Passing result for task 7.
        send_result(1'b0, 2'd0, 4'd7);
        read_check("t7_exception", 3'd0, 32'h07);
        read_check("t7_success", 3'd1, 32'h0080);
        read_check("t7_fail", 3'd2, 32'hFFFF_FFFF);
        do_write(3'd0, 32'hDEAD_BEEF);
        check_output("clear_irq", {31'b0, irq}, 32'h0);

        // Collision on task 3, logical core 1.
        send_result(1'b1, 2'd1, 4'd3);
        read_check("t3_exception", 3'd0, 32'h13);
        read_check("t3_fail", 3'd2, 32'hFFFF_FF7F);
        read_check("t3_success", 3'd1, 32'h0);
        do_write(3'd0, 32'h0);
        check_output("clear_irq2", {31'b0, irq}, 32'h0);
        read_check("clr_exception", 3'd0, 32'h0);
        read_check("clr_success", 3'd1, 32'h0);
        read_check("clr_fail", 3'd2, 32'hFFFF_FFFF);

        // Every task x logical x collision combination.
        for (int t = 0; t < 16; t++) begin
            for (int l = 0; l < 3; l++) begin
                for (int c = 0; c < 2; c++) begin
                    exp_fail = 32'hFFFF_FFFF;
                    if (c == 1) exp_fail[2*t +: 2] = 2'(l);
                    send_result(1'(c), 2'(l), 4'(t));
                    read_check("sweep_exception", 3'd0, {27'b0, 1'(c), 4'(t)});
                    read_check("sweep_success", 3'd1, (c == 1) ? 32'h0 : (32'h1 << t));
                    read_check("sweep_fail", 3'd2, exp_fail);
                    do_write(3'd0, 32'h0);
                    check_output("sweep_clear", {31'b0, irq}, 32'h0);
                end
            end
        end

        // A held request stalls while irq is set and is accepted after the clear.
        send_result(1'b0, 2'd0, 4'd1);
        comparator_status_write       = 1'b1;
        comparator_collision_detected = 1'b0;
        comparator_task_id            = 4'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("stall_no_ack", {31'b0, csr_status_ack}, 32'h0);
        end
        csr_address = 3'd0;
        csr_write   = 1'b1;
        tick();
        check_output("clear_beats_result", {30'b0, irq, csr_status_ack}, 32'h0);
        csr_write = 1'b0;
        tick();
        check_output("stall_ack", {30'b0, irq, csr_status_ack}, 32'h3);
        comparator_status_write = 1'b0;
        tick();
        read_check("stall_success", 3'd1, 32'h0200);

        // Read and write together: the write (exception clear) wins.
        do_read(3'd1, last_read);
        csr_address = 3'd0;
        csr_read    = 1'b1;
        csr_write   = 1'b1;
        tick();
        csr_read  = 1'b0;
        csr_write = 1'b0;
        tick();
        check_output("rw_irq", {31'b0, irq}, 32'h0);
        check_output("rw_readdata", csr_readdata, last_read);

        // Reset in the middle of a maxcount handshake.
        send_result(1'b1, 2'd2, 4'd4);
        csr_address   = 3'd4;
        csr_writedata = 32'h0103_0011;
        csr_write     = 1'b1;
        tick();
        check_output("pending_strobe", strobes(), 32'h4);
        reset = 1'b1;
        #1;
        check_output("reset_strobe", strobes(), 32'h0);
        check_output("reset_fields", fields(), 32'h0);
        check_output("reset_irq", {30'b0, irq, csr_status_ack}, 32'h0);
        check_output("reset_readdata", csr_readdata, 32'h0);
        csr_write = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check_output("post_reset_wait", {31'b0, csr_waitrequest}, 32'h0);
        read_check("post_reset_exception", 3'd0, 32'h0);
        read_check("post_reset_success", 3'd1, 32'h0);
        read_check("post_reset_fail", 3'd2, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/comparator_csr_registers.md
Name: comparator_csr_registers

Overview:
- Avalon-MM slave control/status register block for the NMR fingerprint comparator.
- The Nios processor writes configuration through it; each write is forwarded over a strobe/ack handshake to the core-assignment table, maxcount counters or directory pointers.
- It records comparator results in success, fail and exception registers, raises an interrupt, and clears it when the processor writes the exception register.

Parameters:
- DATA_WIDTH, 32, Avalon data width.
- CSR_ADDR_WIDTH, 3, word address width.
- KEY_WIDTH, 4, task-id and physical-core-id width.
- KEY_SIZE, 16, number of tasks (2**KEY_WIDTH).
- RAM_ADDR_WIDTH, 6, width of maxcount and pointer data.

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- csr_address  in  CSR_ADDR_WIDTH  word offset.
- csr_read  in  1  read request.
- csr_readdata  out  DATA_WIDTH  read data.
- csr_write  in  1  write request.
- csr_writedata  in  DATA_WIDTH  write data.
- csr_waitrequest  out  1  Avalon waitrequest.
- csr_logical_core_id  out  2  latched writedata[25:24].
- csr_task_id  out  KEY_WIDTH  latched writedata[16+:KEY_WIDTH].
- csr_physical_core_id  out  KEY_WIDTH  latched writedata[KEY_WIDTH-1:0].
- comparator_status_write  in  1  comparator result request (level, held until ack).
- comparator_collision_detected  in  1  1 = mismatch.
- comparator_logical_core_id  in  2  faulty logical core.
- comparator_task_id  in  KEY_WIDTH  task.
- csr_status_ack  out  1  one-cycle result-accept pulse.
- csr_cat_write  out  1  core-assignment-table write strobe.
- fprint_cat_ack  in  1  ack for csr_cat_write.
- csr_maxcount_write  out  1  maxcount write strobe.
- csr_maxcount_data  out  RAM_ADDR_WIDTH  latched writedata[RAM_ADDR_WIDTH-1:0].
- counter_maxcount_ack  in  1  ack for csr_maxcount_write.
- csr_pointer_start_write  out  1  directory start pointer strobe.
- csr_pointer_end_write  out  1  directory end pointer strobe.
- csr_pointer_data  out  RAM_ADDR_WIDTH  latched writedata[RAM_ADDR_WIDTH-1:0].
- comp_pointer_ack  in  1  ack for both pointer strobes.
- irq  out  1  pending-exception interrupt.

Behaviour:
- Address map:
  - 0 EXCEPTION (R/W): bit4 = collision flag, bits[3:0] = task id.
  - 1 SUCCESS (R): bit t = task t passed.
  - 2 FAIL (R): bits[2t+1:2t] = faulty logical core of task t; 2'b11 means none.
  - 3 CORE_ASSIGNMENT (W).
  - 4 MAXCOUNT (W).
  - 5 DIRECTORY_START (W).
  - 6 DIRECTORY_END (W).
  - Unmapped or write-only reads return 0. Writes to offsets 1, 2 and 7 are ignored and complete normally.
- Reset values: all strobes 0, csr_status_ack 0, irq 0, csr_readdata 0, latched field outputs 0, EXCEPTION 0, SUCCESS 0, FAIL all ones. State goes to IDLE. Reset during a handshake abandons it.
- Waitrequest: csr_waitrequest = (csr_read | csr_write) & (state != DONE), combinational.
- State machine: IDLE, CAT_WAIT, MAX_WAIT, PSTART_WAIT, PEND_WAIT, DONE.
- IDLE + read: register readdata from the addressed register, go to DONE. Read latency is 2 cycles; readdata is valid during DONE and held afterwards.
- IDLE + write to 3/4/5/6: latch logical id, task id, physical id and data fields, assert the matching strobe, go to the matching *_WAIT state.
- *_WAIT: hold the strobe high until its ack is sampled high. Then drop the strobe and go to DONE.
- IDLE + write to 0: clear EXCEPTION, SUCCESS := 0, FAIL := all ones, irq := 0; go to DONE. Writedata is ignored.
- DONE always returns to IDLE after 1 cycle. A request still asserted in the following IDLE starts a new transaction.
- read and write asserted together: write wins.
- Comparator acceptance: a result is accepted when comparator_status_write=1, irq=0, and no exception-clear write is occurring in the same cycle. The clear has priority.
- On accept:
  - EXCEPTION := {collision, task}.
  - collision=0: SUCCESS[task] := 1.
  - collision=1: FAIL[2task+:2] := logical id.
  - irq := 1, csr_status_ack pulses for 1 cycle.
- While irq=1, further comparator requests are stalled, with no ack.
- Latched field outputs hold their value until the next configuration write.

Test Plan:
- Write 0x0205000A to offset 3 -> csr_cat_write rises with logical=2, task=5, physical=10. Assert fprint_cat_ack -> strobe drops and waitrequest drops for 1 cycle.
- For every task 0-15 and logical 0-2, write logical<<24|task<<16|21 to offsets 4, 5 and 6 -> each correct strobe is asserted with data 21 and the correct ids, and no other strobe toggles.
- Comparator sends collision=0, task=7 -> ack pulse and irq=1. EXCEPTION reads 0x07, SUCCESS reads 0x0080, FAIL reads 0xFFFFFFFF.
- Comparator sends collision=1, logical=1, task=3 -> EXCEPTION reads 0x13, FAIL[7:6]=01 with all other pairs 11.
- Write 0 to offset 0 -> irq=0, SUCCESS=0, FAIL=0xFFFFFFFF. Repeat across all 16x3x2 combinations; only the current task's bit or pair is ever set.
- Hold comparator_status_write with irq=1 -> no ack until the clear write, then ack. Assert reset while csr_maxcount_write is pending -> strobe=0 and all registers return to reset values.
